cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Arbitrates a single shared SRAM port between the instruction-fetch unit (read-only) and the data-memory stage (read/write) of the 32-bit CPU.
- Sits between the pipeline and the memory pins, inside cpu_controller.
- Fixed priority to data accesses, with a starvation guard for fetch.
- SRAM has no ready signal, so the arbiter counts wait states itself.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (DATA_W/8 byte enables).
- WAIT_CYCLES, 2, extra cycles the SRAM needs per access (0 allowed).
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1=write.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  read data.
- mem_ce  out  1  SRAM chip enable.
- mem_we  out  1  SRAM write enable.
- mem_be  out  DATA_W/8  SRAM byte enables.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data.
- busy  out  1  state != IDLE.
- grant_id  out  1  owner of the current or last transaction (0=fetch, 1=data).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: every output is 0, state=IDLE, starve_cnt=0, wait counter=0.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.

- IDLE:
  - If d_req=1 and !(if_req=1 and starve_cnt==STARVE_LIMIT): grant data.
  - Else if if_req=1: grant fetch.
  - On grant: latch addr, wdata, be and we into internal registers, set grant_id, load wait counter with WAIT_CYCLES, go to ACCESS.
  - Fetch latches we=0 and be=all ones.
  - No request: stay in IDLE; mem_ce=0.

- ACCESS:
  - mem_ce=1; mem_we=latched we; mem_addr, mem_wdata and mem_be come from the latched registers only. Requester inputs are ignored while busy.
  - Lasts WAIT_CYCLES+1 cycles; the counter decrements each cycle.
  - In the cycle the counter is 0: for a read, capture mem_rdata into if_rdata or d_rdata (per grant), then go to RESP.
  - Writes never update d_rdata.

- RESP:
  - mem_ce=0, mem_we=0.
  - The granted ack is 1 for exactly this cycle; the other ack stays 0. Go to IDLE.
  - rdata registers hold their value until the next read to the same port.

- Latency: request sampled in IDLE at cycle 0 -> ack in cycle WAIT_CYCLES+2. Back-to-back throughput is one transfer per WAIT_CYCLES+3 cycles.

- Handshake:
  - The requester holds req, addr and data stable until it sees ack.
  - req still high in the IDLE cycle after RESP is a new request.
  - Dropping req mid-transaction does not abort: the access completes and ack still pulses.

- Starvation counter:
  - On a data grant with if_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - On a data grant with if_req=0, or on any fetch grant: starve_cnt=0.

- Simultaneous requests: data wins unless the starvation condition holds.

- Reset mid-operation:
  - mem_ce, mem_we and both acks drop asynchronously; no ack is issued for the aborted transaction.
  - Requesters must reissue; the SRAM contents for an aborted write are undefined.

Test Plan:
1. Reset, then if_req=1, if_addr=0x00000010, mem_rdata=0x8C220004, WAIT_CYCLES=2 -> mem_ce high in cycles 1-3 with mem_addr=0x10, mem_we=0; if_ack pulses in cycle 4; if_rdata=0x8C220004; grant_id=0.
2. Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_be=0011 and mem_wdata=0xDEADBEEF for 3 cycles; d_ack in cycle 4; d_rdata unchanged.
3. if_req and d_req both held high continuously with STARVE_LIMIT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F; each ack lands 5 cycles apart; never two acks in the same cycle.
4. Change d_addr from 0x100 to 0x200 during ACCESS, and drop d_req -> mem_addr stays 0x100; d_ack still pulses once.
5. Assert rst in the second ACCESS cycle of a read -> mem_ce, busy and acks go to 0 immediately, with no ack; after release with if_req=1, a fresh access completes normally.
6. WAIT_CYCLES=0, single fetch -> mem_ce high for exactly 1 cycle; if_ack in cycle 2.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Shared SRAM port arbiter: instruction fetch (read-only) vs data stage (read/write).
// Data has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module cpu_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // SRAM pins
  output logic                mem_ce,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status
  output logic                busy,
  output logic                grant_id,
  output logic [1:0]          dbg_state
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LOAD  = WCNT_W'(WAIT_CYCLES);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [SCNT_W-1:0]   r_starve_cnt;
  logic                r_grant_id;
  logic                r_if_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_mem_ce;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_force_if;
  logic                w_grant_d;
  logic                w_grant_if;
  logic [SCNT_W-1:0]   w_starve_next;

  // Handshake: a requester raises req with stable addr/data and holds them until its
  // one-cycle ack; inputs are sampled only in IDLE, so a req still high after the ack
  // is taken as a new request, and a req dropped mid-access still completes and acks.

  always_comb begin
    w_force_if    = if_req && (r_starve_cnt == STARVE_MAX);
    w_grant_d     = d_req && !w_force_if;
    w_grant_if    = if_req && !w_grant_d;
    w_starve_next = '0;
    // Only a data win over a waiting fetch counts toward starvation.
    if (w_grant_d && if_req) begin
      if (r_starve_cnt == STARVE_MAX) w_starve_next = STARVE_MAX;
      else                            w_starve_next = r_starve_cnt + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_grant_id   <= 1'b0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_mem_ce     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          if (w_grant_d) begin
            r_grant_id  <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_be    <= d_be;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (w_grant_if) begin
            r_grant_id  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '1;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
          end
          if (w_grant_d || w_grant_if) begin
            r_mem_ce     <= 1'b1;
            r_wait_cnt   <= WAIT_LOAD;
            r_starve_cnt <= w_starve_next;
            r_state      <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (r_wait_cnt == '0) begin
            // Last access cycle: SRAM read data is valid now.
            if (!r_mem_we) begin
              if (r_grant_id) r_d_rdata  <= mem_rdata;
              else            r_if_rdata <= mem_rdata;
            end
            if (r_grant_id) r_d_ack  <= 1'b1;
            else            r_if_ack <= 1'b1;
            r_mem_ce <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
          end
        end

        S_RESP: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_mem_ce <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_grant_id;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: directed scenarios push expected acks,
// monitors pop and compare on each ack; a second instance covers WAIT_CYCLES=0.
module tb_cpu_mem_arbiter;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // main instance signals (WAIT_CYCLES=2, STARVE_LIMIT=4)
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_ce, mem_we, busy, grant_id;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  // zero-wait instance signals
  logic        z_if_req, z_if_ack, z_d_ack;
  logic [31:0] z_if_addr, z_if_rdata, z_d_rdata;
  logic [3:0]  z_mem_be;
  logic        z_mem_ce, z_mem_we, z_busy, z_grant_id;
  logic [31:0] z_mem_addr, z_mem_wdata, z_mem_rdata;
  logic [1:0]  z_dbg_state;

  // SRAM contents: one known instruction word, everything else tagged with its address
  function automatic logic [31:0] sram_word(logic [31:0] a);
    return (a == 32'h10) ? 32'h8C220004 : {16'hC0DE, a[15:0]};
  endfunction
  assign mem_rdata   = sram_word(mem_addr);
  assign z_mem_rdata = sram_word(z_mem_addr);

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_LIMIT(4)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_ce(z_mem_ce), .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
    .busy(z_busy), .grant_id(z_grant_id), .dbg_state(z_dbg_state)
  );

  // scoreboard: {is_data, is_write, rdata, ack_cycle[15:0]}
  logic [49:0] exp_q[$];
  logic [49:0] z_q[$];

  function automatic logic [49:0] mk(logic is_d, logic is_wr, logic [31:0] rd, int cy);
    return {is_d, is_wr, rd, cy[15:0]};
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor, main instance
  always @(negedge clk) begin
    logic [49:0] e;
    if (!rst && (if_ack || d_ack)) begin
      check("ack_exclusive", 32'(if_ack & d_ack), 32'h0);
      if (exp_q.size() == 0) begin
        check("spurious_ack", {30'h0, if_ack, d_ack}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 32'(d_ack), 32'(e[49]));
        check("grant_id", 32'(grant_id), 32'(e[49]));
        check("ack_cycle", {16'h0, cyc[15:0]}, {16'h0, e[15:0]});
        if (e[49]) check("d_rdata", d_rdata, e[47:16]);
        else       check("if_rdata", if_rdata, e[47:16]);
      end
    end
  end

  // monitor, zero-wait instance
  always @(negedge clk) begin
    logic [49:0] e;
    if (!rst && (z_if_ack || z_d_ack)) begin
      if (z_q.size() == 0) begin
        check("z_spurious_ack", {30'h0, z_if_ack, z_d_ack}, 32'h0);
      end else begin
        e = z_q.pop_front();
        check("z_ack_port", 32'(z_d_ack), 32'(e[49]));
        check("z_ack_cycle", {16'h0, cyc[15:0]}, {16'h0, e[15:0]});
        check("z_if_rdata", z_if_rdata, e[47:16]);
      end
    end
  end

  // wait until the chosen queue empties; lands 1ns after a falling edge
  task automatic drain(input logic zero_inst, input int budget);
    int n = 0;
    while (((zero_inst ? z_q.size() : exp_q.size()) != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", zero_inst ? z_q.size() : exp_q.size(), 32'h0);
    if (zero_inst) z_q.delete();
    else           exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    z_if_req = 0; z_if_addr = 0;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_if_ack", 32'(if_ack), 32'h0);
    check("rst_d_ack", 32'(d_ack), 32'h0);
    check("rst_mem_ce", 32'(mem_ce), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("rst_z_mem_ce", 32'(z_mem_ce), 32'h0);
    rst = 1'b0;

    // single fetch, two wait states
    @(negedge clk);
    c = cyc; if_req = 1; if_addr = 32'h10;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h8C220004, c + 4));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      check("t1_mem_ce", 32'(mem_ce), 32'(i <= 3));
      if (i <= 3) begin
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_we", 32'(mem_we), 32'h0);
        check("t1_mem_be", 32'(mem_be), 32'hF);
        check("t1_busy", 32'(busy), 32'h1);
      end
    end
    drain(1'b0, 20);
    if_req = 0;

    // data write with partial byte enables
    @(negedge clk);
    c = cyc; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0, c + 4));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      check("t2_mem_ce", 32'(mem_ce), 32'h1);
      check("t2_mem_we", 32'(mem_we), 32'h1);
      check("t2_mem_be", 32'(mem_be), 32'h3);
      check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("t2_mem_addr", mem_addr, 32'h100);
    end
    drain(1'b0, 20);
    d_req = 0; d_we = 0;

    // inputs change and req drops mid-access; access completes at the old address
    @(negedge clk);
    c = cyc; d_req = 1; d_addr = 32'h100; d_be = 4'hF;
    exp_q.push_back(mk(1'b1, 1'b0, 32'hC0DE0100, c + 4));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin d_addr = 32'h200; d_req = 0; end
      check("t4_mem_addr", mem_addr, 32'h100);
      check("t4_mem_ce", 32'(mem_ce), 32'h1);
    end
    drain(1'b0, 20);
    repeat (6) @(negedge clk);
    check("t4_idle_busy", 32'(busy), 32'h0);
    check("if_rdata_hold", if_rdata, 32'h8C220004);

    // both requesters held: D,D,D,D,F,D,D,D,D,F five cycles apart
    @(negedge clk);
    c = cyc; if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      logic f;
      f = (k == 4) || (k == 9);
      exp_q.push_back(mk(!f, 1'b0, f ? 32'hC0DE0040 : 32'hC0DE0080, c + 4 + 5 * k));
    end
    drain(1'b0, 80);
    if_req = 0; d_req = 0;
    repeat (2) @(negedge clk);

    // reset in the second access cycle of a read
    @(negedge clk);
    c = cyc; if_req = 1; if_addr = 32'h10;
    repeat (2) @(negedge clk);
    check("t5_pre_mem_ce", 32'(mem_ce), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t5_mem_ce", 32'(mem_ce), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_if_ack", 32'(if_ack), 32'h0);
    check("t5_d_ack", 32'(d_ack), 32'h0);
    check("t5_mem_we", 32'(mem_we), 32'h0);
    check("t5_if_rdata", if_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h8C220004, c + 4));
    drain(1'b0, 20);
    if_req = 0;

    // zero wait states: one access cycle, ack two cycles after the request
    @(negedge clk);
    c = cyc; z_if_req = 1; z_if_addr = 32'h10;
    z_q.push_back(mk(1'b0, 1'b0, 32'h8C220004, c + 2));
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); #1;
      check("t6_mem_ce", 32'(z_mem_ce), 32'(i == 1));
    end
    drain(1'b1, 10);
    z_if_req = 0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
